tmr_shift_register: RTL

Parametrised triple-modular-redundant shift register, the successor to the fixed-width TMR register. It holds three replica lanes and a configurable-width datapath supporting the four shift/load modes. It adds per-replica health tracking, which permanently excludes a persistently faulty lane from the vote, and degraded-mode voting with an uncorrectable-error flag. A saturating correction counter is exposed for the status/telemetry logic.

---
 rtl/tmr_pkg.sv | 26 ++
 rtl/tmr_lane.sv | 103 ++++++++++
 rtl/tmr_shift_register.sv | 117 +++++++++++
 3 files changed

// File: rtl/tmr_pkg.sv
// Shared types and helpers for the TMR shift register.
// Mode and health encodings plus the bitwise voter.
package tmr_pkg;

    typedef enum logic [1:0] {
        MODE_SHR  = 2'b00,
        MODE_SHL  = 2'b01,
        MODE_PISO = 2'b10,
        MODE_PIPO = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        HEALTHY = 2'b00,
        SUSPECT = 2'b01,
        FAILED  = 2'b10
    } health_e;

    function automatic logic maj3(
        input logic a,
        input logic b,
        input logic c
    );
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/tmr_lane.sv
// One replica lane: datapath register, scrub/base mux
// and the health FSM that tracks consecutive mismatches.
module tmr_lane
    import tmr_pkg::*;
#(
    parameter int WIDTH       = 128,
    parameter int FAIL_THRESH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable_i,
    input  logic [1:0]       mode_i,
    input  logic             load_i,
    input  logic             serial_in_i,
    input  logic [WIDTH-1:0] parallel_in_i,
    input  logic [WIDTH-1:0] voted_i,
    input  logic             correct_i,
    input  logic             mismatch_i,
    input  logic             clr_fail_i,
    output logic [WIDTH-1:0] data_o,
    output logic             failed_o
);

    localparam int CW = $clog2(FAIL_THRESH + 1);
    localparam logic [CW-1:0] THRESH = CW'(FAIL_THRESH);

    logic [WIDTH-1:0] data_q, data_d, base;
    health_e          state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d, cnt_inc;
    mode_e            mode_s;

    assign mode_s   = mode_e'(mode_i);
    assign cnt_inc  = cnt_q + CW'(1);
    assign data_o   = data_q;
    assign failed_o = (state_q == FAILED);

    // Next lane word: pick corrected or own word, then apply the mode
    always_comb begin
        base   = correct_i ? voted_i : data_q;
        data_d = base;
        if (enable_i) begin
            unique case (mode_s)
                MODE_SHR:  data_d = {serial_in_i, base[WIDTH-1:1]};
                MODE_SHL:  data_d = {base[WIDTH-2:0], serial_in_i};
                MODE_PISO: data_d = load_i ? parallel_in_i
                                           : {1'b0, base[WIDTH-1:1]};
                MODE_PIPO: data_d = load_i ? parallel_in_i : base;
                default:   data_d = base;
            endcase
        end
    end

    // Health FSM next state; clr_fail overrides mismatch tracking
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (clr_fail_i) begin
            state_d = HEALTHY;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                HEALTHY: begin
                    if (mismatch_i) begin
                        state_d = SUSPECT;
                        cnt_d   = CW'(1);
                    end
                end
                SUSPECT: begin
                    if (mismatch_i) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == THRESH) begin
                            state_d = FAILED;
                        end
                    end else begin
                        state_d = HEALTHY;
                        cnt_d   = '0;
                    end
                end
                FAILED: begin
                    state_d = FAILED;
                end
                default: begin
                    state_d = HEALTHY;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Lane and health registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            state_q <= HEALTHY;
            cnt_q   <= '0;
        end else begin
            data_q  <= data_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/tmr_shift_register.sv
// Triple-redundant shift register top: three lanes, a
// health-aware voter, serial tap and correction counter.
module tmr_shift_register
    import tmr_pkg::*;
#(
    parameter int WIDTH       = 128,
    parameter int FAIL_THRESH = 3,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [1:0]       mode,
    input  logic             load,
    input  logic             serial_in,
    input  logic [WIDTH-1:0] parallel_in,
    input  logic             clr_fail,
    output logic [WIDTH-1:0] parallel_out,
    output logic             serial_out,
    output logic [2:0]       fault_vec,
    output logic [2:0]       failed_vec,
    output logic             degraded,
    output logic             uncorrectable,
    output logic [CNT_W-1:0] corr_count
);

    logic [2:0][WIDTH-1:0] lane_data;
    logic [WIDTH-1:0]      maj_w, voted;
    logic                  unc;
    logic [2:0]            correct;
    logic [CNT_W-1:0]      corr_q, corr_d;

    for (genvar i = 0; i < 3; i++) begin : g_lane
        tmr_lane #(
            .WIDTH      (WIDTH),
            .FAIL_THRESH(FAIL_THRESH)
        ) u_lane (
            .clk          (clk),
            .rst          (rst),
            .enable_i     (enable),
            .mode_i       (mode),
            .load_i       (load),
            .serial_in_i  (serial_in),
            .parallel_in_i(parallel_in),
            .voted_i      (voted),
            .correct_i    (correct[i]),
            .mismatch_i   (fault_vec[i]),
            .clr_fail_i   (clr_fail),
            .data_o       (lane_data[i]),
            .failed_o     (failed_vec[i])
        );
    end

    // Vote over the lanes still trusted; fall back when too few agree
    always_comb begin
        for (int b = 0; b < WIDTH; b++) begin
            maj_w[b] = maj3(lane_data[0][b], lane_data[1][b],
                            lane_data[2][b]);
        end
        voted = maj_w;
        unc   = 1'b0;
        unique case (failed_vec)
            3'b000: voted = maj_w;
            3'b001: begin
                voted = lane_data[1];
                unc   = (lane_data[1] != lane_data[2]);
            end
            3'b010: begin
                voted = lane_data[0];
                unc   = (lane_data[0] != lane_data[2]);
            end
            3'b100: begin
                voted = lane_data[0];
                unc   = (lane_data[0] != lane_data[1]);
            end
            3'b011:  voted = lane_data[2];
            3'b101:  voted = lane_data[1];
            3'b110:  voted = lane_data[0];
            default: begin
                voted = maj_w;
                unc   = 1'b1;
            end
        endcase
    end

    // Per-lane disagreement and whether a correction may be written
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            fault_vec[i] = (lane_data[i] != voted);
            correct[i]   = fault_vec[i] & ~unc;
        end
    end

    // Count correcting cycles, holding at the top value
    always_comb begin
        corr_d = corr_q;
        if ((|fault_vec) && !unc && (corr_q != '1)) begin
            corr_d = corr_q + CNT_W'(1);
        end
    end

    // Correction counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            corr_q <= '0;
        end else begin
            corr_q <= corr_d;
        end
    end

    assign parallel_out  = voted;
    assign serial_out    = mode[0] ? voted[WIDTH-1] : voted[0];
    assign degraded      = |failed_vec;
    assign uncorrectable = unc;
    assign corr_count    = corr_q;

endmodule
